r16_lane_gather: RTL and testbench
==================================

// Module: r16_lane_gather
// PURPOSE
//  Serial-to-parallel gather stage directly downstream of the radix-16 pipeline register.
//  Consumes the registered sample stream (A0/Ac) one sample per cycle.
//  Packs every 16 consecutive valid samples into one 16-lane vector for the radix-16 butterfly.
//  Tags each vector with its group index within a 16384-point frame (1024 groups).
// PARAMETERS
//  P_WIDTH   64      width of one sample (bits)
//  P_ZERO    64'h0   reset/clear value of one sample
//  P_GROUPS  1024    groups per frame (frame points / 16)
//  P_GBITS   10      width of group index, clog2(P_GROUPS)
// PORTS
//  clk       in   1             rising-edge clock
//  rst       in   1             asynchronous, active-high reset
//  A0_in     in   P_WIDTH       input sample
//  Ac_in     in   1             A0_in valid this cycle
//  sync_in   in   1             frame restart; the current cycle becomes slot 0, group 0
//  B_out     out  16*P_WIDTH    gathered vector; lane k = B_out[k*P_WIDTH +: P_WIDTH]
//  Bv_out    out  1             B_out valid, one-cycle pulse
//  Bg_out    out  P_GBITS       group index of B_out
//  Bf_out    out  1             first group of frame (Bg_out==0), qualified by Bv_out
//  drop_out  out  1             pulse: partial group discarded by sync_in
// BEHAVIOUR
//  - Reset (rst=1, async): B_out=all P_ZERO; Bv_out, Bf_out, drop_out=0; Bg_out=0.
//    Reset also clears slot counter, group counter and lane store to P_ZERO.
//  - Slot counter slot[3:0]: on each cycle with Ac_in=1, A0_in is written to lane[slot], then slot increments mod 16.
//    Cycles with Ac_in=0 change nothing. Gaps inside a group are allowed.
//  - Group completion: the cycle with Ac_in=1 and slot==15 completes a group.
//    On the next edge: B_out = {lanes 0..14 stored, lane15 = that A0_in}; Bv_out=1; Bg_out=grp; Bf_out=(grp==0).
//  - Latency: Bv_out rises 1 clk after the 16th valid sample is presented. Any later valid sample cannot disturb B_out.
//  - No backpressure: back-to-back groups (Ac_in held high) yield Bv_out=1 every 16th cycle. The lane store is reused immediately.
//  - B_out/Bg_out hold their last value while Bv_out=0. Bv_out, Bf_out and drop_out are single-cycle pulses.
//  - Group counter grp: increments on each completion. Wraps P_GROUPS-1 -> 0 with no extra flag; Bf_out marks the wrap.
//  - sync_in=1 takes priority over normal counting:
//    - slot and grp are forced to 0.
//    - If Ac_in=1 in the same cycle, A0_in is written to lane0 and slot becomes 1.
//    - If slot!=0 before sync, drop_out=1 next cycle and the partial group is discarded (never emitted).
//    - sync_in with slot==0 gives drop_out=0.
//  - Completion and sync_in in the same cycle: sync wins. The group is discarded with drop_out=1 and Bv_out=0.
//  - Stale lane contents are not cleared by sync. Every emitted vector contains only samples from its own group.
//  - Reset mid-group: the partial group is lost and no pulse is emitted. Counting restarts at slot 0, grp 0.
// TESTING
//  1. Reset, then Ac_in=1 for 16 cycles, A0_in=0..15 -> one clk after sample 15: Bv_out=1, lane k=k, Bg_out=0, Bf_out=1.
//  2. Continuous Ac_in=1 for 16*1025 samples -> Bv_out every 16 clks; Bg_out 0..1023 then 0; Bf_out on groups 0 and 1024.
//  3. 16 samples with Ac_in toggling 1/0 -> Bv_out once, 1 clk after the 16th valid sample; data intact.
//  4. 5 samples, then sync_in=1 with Ac_in=1, A0_in=0xAA, then 15 samples -> drop_out=1 once; next vector lane0=0xAA, Bg_out=0.
//  5. sync_in asserted on the 16th sample of group 3 -> no Bv_out, drop_out=1; next completed vector has Bg_out=0.
//  6. rst pulsed after 7 samples -> outputs zero immediately; the next 16 samples emit Bg_out=0 with lanes exactly those 16.

Source files
------------

// File: rtl/r16_lane_gather.sv
// r16_lane_gather
// Serial-to-parallel gather stage for the radix-16 butterfly. Collects 16
// consecutive valid samples into one 16-lane vector and tags each vector with
// its group index inside the current frame. A frame restart (sync_in)
// discards any partially gathered group and restarts slot/group counting.
// Lanes 0..14 are held in a store; lane 15 is taken straight from the input
// on the completing cycle, so the vector register is loaded in one edge.

module r16_lane_gather #(
  parameter int                 P_WIDTH  = 64,
  parameter logic [P_WIDTH-1:0] P_ZERO   = 64'h0,
  parameter int                 P_GROUPS = 1024,
  parameter int                 P_GBITS  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_WIDTH-1:0]      A0_in,
  input  logic                    Ac_in,
  input  logic                    sync_in,
  output logic [16*P_WIDTH-1:0]   B_out,
  output logic                    Bv_out,
  output logic [P_GBITS-1:0]      Bg_out,
  output logic                    Bf_out,
  output logic                    drop_out
);

  localparam int                 LANES     = 16;
  localparam int                 STORED    = LANES - 1;
  localparam logic [3:0]         SLOT_ZERO = 4'd0;
  localparam logic [3:0]         SLOT_ONE  = 4'd1;
  localparam logic [3:0]         SLOT_LAST = 4'd15;
  localparam logic [P_GBITS-1:0] GRP_ZERO  = {P_GBITS{1'b0}};
  localparam logic [P_GBITS-1:0] GRP_ONE   = {{(P_GBITS-1){1'b0}}, 1'b1};
  localparam logic [P_GBITS-1:0] GRP_LAST  = P_GBITS'(P_GROUPS - 1);

  // Counters and lane store.
  logic [3:0]           slot_r;
  logic [P_GBITS-1:0]   grp_r;
  logic [P_WIDTH-1:0]   lane_r [0:STORED-1];

  // Output registers.
  logic [16*P_WIDTH-1:0] b_r;
  logic                  bv_r;
  logic [P_GBITS-1:0]    bg_r;
  logic                  bf_r;
  logic                  drop_r;

  // Per-cycle decode.
  logic [3:0]            slot_nxt_s;
  logic [P_GBITS-1:0]    grp_nxt_s;
  logic                  wr_en_s;
  logic [3:0]            wr_idx_s;
  logic                  emit_s;
  logic                  drop_s;
  logic                  first_s;
  logic [16*P_WIDTH-1:0] gather_s;

  // Decode sync / valid / completion into counter updates and pulse requests.
  always_comb begin
    slot_nxt_s = slot_r;
    grp_nxt_s  = grp_r;
    wr_en_s    = 1'b0;
    wr_idx_s   = slot_r;
    emit_s     = 1'b0;
    drop_s     = 1'b0;
    if (sync_in) begin
      // Frame restart wins over everything, including a completing sample.
      grp_nxt_s = GRP_ZERO;
      drop_s    = (slot_r != SLOT_ZERO);
      if (Ac_in) begin
        wr_en_s    = 1'b1;
        wr_idx_s   = SLOT_ZERO;
        slot_nxt_s = SLOT_ONE;
      end else begin
        slot_nxt_s = SLOT_ZERO;
      end
    end else if (Ac_in) begin
      wr_en_s    = 1'b1;
      wr_idx_s   = slot_r;
      slot_nxt_s = slot_r + SLOT_ONE;
      if (slot_r == SLOT_LAST) begin
        emit_s = 1'b1;
        if (grp_r == GRP_LAST) begin
          grp_nxt_s = GRP_ZERO;
        end else begin
          grp_nxt_s = grp_r + GRP_ONE;
        end
      end else begin
        emit_s = 1'b0;
      end
    end else begin
      slot_nxt_s = slot_r;
      grp_nxt_s  = grp_r;
    end
  end

  // First-group flag for the vector being completed this cycle.
  always_comb begin
    first_s = 1'b0;
    if (grp_r == GRP_ZERO) begin
      first_s = 1'b1;
    end else begin
      first_s = 1'b0;
    end
  end

  // Assemble the outgoing vector: stored lanes 0..14 plus the live sample as lane 15.
  always_comb begin
    gather_s = {(16*P_WIDTH){1'b0}};
    for (int k = 0; k < STORED; k++) begin
      gather_s[k*P_WIDTH +: P_WIDTH] = lane_r[k];
    end
    gather_s[STORED*P_WIDTH +: P_WIDTH] = A0_in;
  end

  // Slot and group counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r <= SLOT_ZERO;
      grp_r  <= GRP_ZERO;
    end else begin
      slot_r <= slot_nxt_s;
      grp_r  <= grp_nxt_s;
    end
  end

  // Lane store for slots 0..14; slot 15 never needs storing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STORED; k++) begin
        lane_r[k] <= P_ZERO;
      end
    end else begin
      for (int k = 0; k < STORED; k++) begin
        if (wr_en_s && (wr_idx_s == 4'(k))) begin
          lane_r[k] <= A0_in;
        end
      end
    end
  end

  // Vector and group tag: load on completion, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_r  <= {LANES{P_ZERO}};
      bg_r <= GRP_ZERO;
    end else if (emit_s) begin
      b_r  <= gather_s;
      bg_r <= grp_r;
    end
  end

  // Single-cycle pulses: valid, first-of-frame and dropped-partial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bv_r   <= 1'b0;
      bf_r   <= 1'b0;
      drop_r <= 1'b0;
    end else begin
      bv_r   <= emit_s;
      bf_r   <= emit_s & first_s;
      drop_r <= drop_s;
    end
  end

  assign B_out    = b_r;
  assign Bv_out   = bv_r;
  assign Bg_out   = bg_r;
  assign Bf_out   = bf_r;
  assign drop_out = drop_r;

endmodule

// File: tb/tb_r16_lane_gather.sv
// Directed bench for r16_lane_gather. A reference model of slot/group state
// runs alongside the stimulus; every completed group pushes its expected
// vector onto a scoreboard queue that is popped when Bv_out is seen.

module tb_r16_lane_gather;

  localparam int W = 64;
  localparam int G = 1024;

  typedef struct packed {
    logic [16*W-1:0] data;
    logic [9:0]      grp;
    logic            first;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [W-1:0]    A0_in;
  logic            Ac_in;
  logic            sync_in;
  logic [16*W-1:0] B_out;
  logic            Bv_out;
  logic [9:0]      Bg_out;
  logic            Bf_out;
  logic            drop_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int           slot_m;
  int           grp_m;
  logic [W-1:0] lanes_m [16];
  exp_t         sb_q [$];
  exp_t         last_m;
  int           n_bv;
  int           n_drop;

  r16_lane_gather dut (
    .clk      (clk),
    .rst      (rst),
    .A0_in    (A0_in),
    .Ac_in    (Ac_in),
    .sync_in  (sync_in),
    .B_out    (B_out),
    .Bv_out   (Bv_out),
    .Bg_out   (Bg_out),
    .Bf_out   (Bf_out),
    .drop_out (drop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input exp_t e);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_lane%0d", tag, k), B_out[k*W +: W], e.data[k*W +: W]);
    end
    chk({tag, "_bg"}, W'(Bg_out), W'(e.grp));
  endtask

  task automatic model_reset();
    slot_m = 0;
    grp_m  = 0;
    for (int k = 0; k < 16; k++) lanes_m[k] = '0;
    last_m = '0;
    sb_q.delete();
  endtask

  // One clock of stimulus, model update, then checks #1 after the edge.
  task automatic drive(input string tag, input logic ac, input logic [W-1:0] d, input logic sy);
    logic exp_bv;
    logic exp_drop;
    exp_t e;
    exp_t got;
    exp_bv   = 1'b0;
    exp_drop = 1'b0;
    A0_in    = d;
    Ac_in    = ac;
    sync_in  = sy;
    if (sy) begin
      exp_drop = (slot_m != 0);
      grp_m    = 0;
      if (ac) begin
        lanes_m[0] = d;
        slot_m     = 1;
      end else begin
        slot_m = 0;
      end
    end else if (ac) begin
      lanes_m[slot_m] = d;
      if (slot_m == 15) begin
        for (int k = 0; k < 16; k++) e.data[k*W +: W] = lanes_m[k];
        e.grp   = 10'(grp_m);
        e.first = (grp_m == 0);
        sb_q.push_back(e);
        exp_bv = 1'b1;
        grp_m  = (grp_m + 1) % G;
        slot_m = 0;
      end else begin
        slot_m = slot_m + 1;
      end
    end
    @(posedge clk);
    #1;
    A0_in   = '0;
    Ac_in   = 1'b0;
    sync_in = 1'b0;
    chk({tag, "_bv"}, W'(Bv_out), W'(exp_bv));
    chk({tag, "_drop"}, W'(drop_out), W'(exp_drop));
    if (drop_out === 1'b1) n_drop++;
    if (Bv_out === 1'b1) begin
      n_bv++;
      n_cmp++;
      assert (sb_q.size() > 0) else begin
        n_err++;
        $error("FAIL %s_sb_empty observed=%0d expected=1", tag, sb_q.size());
      end
      if (sb_q.size() > 0) begin
        got    = sb_q.pop_front();
        last_m = got;
        chk_vec(tag, got);
        chk({tag, "_bf"}, W'(Bf_out), W'(got.first));
      end
    end else begin
      chk({tag, "_bf_idle"}, W'(Bf_out), W'(0));
      chk({tag, "_hold_l0"}, B_out[0 +: W], last_m.data[0 +: W]);
      chk({tag, "_hold_l15"}, B_out[15*W +: W], last_m.data[15*W +: W]);
      chk({tag, "_hold_bg"}, W'(Bg_out), W'(last_m.grp));
    end
  endtask

  initial begin
    rst     = 1'b1;
    A0_in   = '0;
    Ac_in   = 1'b0;
    sync_in = 1'b0;
    n_bv    = 0;
    n_drop  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk_vec("rst", last_m);
    chk("rst_bv", W'(Bv_out), W'(0));
    chk("rst_bf", W'(Bf_out), W'(0));
    chk("rst_drop", W'(drop_out), W'(0));
    rst = 1'b0;

    // 1: sixteen samples 0..15.
    for (int i = 0; i < 16; i++) drive("t1", 1'b1, W'(i), 1'b0);
    chk("t1_nbv", W'(n_bv), W'(1));

    // Restart frame at slot 0: no drop expected.
    drive("t2sync", 1'b0, '0, 1'b1);

    // 2: continuous stream across a group-counter wrap.
    n_bv = 0;
    for (int i = 0; i < 16 * 1025; i++) drive("t2", 1'b1, {32'(i / 16), 32'(i) ^ 32'hA5A5_0000}, 1'b0);
    chk("t2_nbv", W'(n_bv), W'(1025));
    chk("t2_grp_after", W'(Bg_out), W'(0));

    // 3: valid toggling, one idle cycle after each sample.
    n_bv = 0;
    for (int i = 0; i < 16; i++) begin
      drive("t3", 1'b1, 64'h3000_0000_0000_0000 + W'(i), 1'b0);
      drive("t3idle", 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    end
    chk("t3_nbv", W'(n_bv), W'(1));

    // 4: partial group of 5, sync with sample 0xAA, then 15 samples.
    n_drop = 0;
    for (int i = 0; i < 5; i++) drive("t4pre", 1'b1, 64'h4000 + W'(i), 1'b0);
    drive("t4sync", 1'b1, 64'hAA, 1'b1);
    for (int i = 0; i < 15; i++) drive("t4", 1'b1, 64'h4100 + W'(i), 1'b0);
    chk("t4_ndrop", W'(n_drop), W'(1));
    chk("t4_lane0", B_out[0 +: W], 64'hAA);

    // 5: sync on the 16th sample of group 3.
    drive("t5sync0", 1'b0, '0, 1'b1);
    for (int i = 0; i < 16 * 3 + 15; i++) drive("t5", 1'b1, 64'h5000 + W'(i), 1'b0);
    drive("t5sync", 1'b1, 64'h5FFF, 1'b1);
    for (int i = 0; i < 15; i++) drive("t5post", 1'b1, 64'h5800 + W'(i), 1'b0);
    chk("t5_bg", W'(Bg_out), W'(0));

    // 6: reset after 7 samples of a group.
    for (int i = 0; i < 7; i++) drive("t6pre", 1'b1, 64'h6000 + W'(i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_vec("t6rst", last_m);
    chk("t6rst_bv", W'(Bv_out), W'(0));
    chk("t6rst_drop", W'(drop_out), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_bv = 0;
    for (int i = 0; i < 16; i++) drive("t6", 1'b1, 64'h6100 + W'(i), 1'b0);
    chk("t6_nbv", W'(n_bv), W'(1));
    chk("t6_sb_left", W'(sb_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
